// File: rtl/thresholding_cfg_ctrl_if.sv
// ----------------------------------------------------------------------------
// thresholding_cfg_ctrl_if: stream, host and cfg bus bundle.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface thresholding_cfg_ctrl_if #(
   parameter int K  = 16,
   parameter int AW = 7
);
   logic          s_vld;
   logic          s_rdy;
   logic [K-1:0]  s_dat;
   logic          hst_en;
   logic          hst_we;
   logic [AW-1:0] hst_a;
   logic [K-1:0]  hst_d;
   logic          hst_rdy;
   logic          hst_rack;
   logic [K-1:0]  hst_q;
   logic          cfg_en;
   logic          cfg_we;
   logic [AW-1:0] cfg_a;
   logic [K-1:0]  cfg_d;
   logic          cfg_rack;
   logic [K-1:0]  cfg_q;

   // slave: the sequencer's view; master: the surrounding system
   modport slave (
      input  s_vld, s_dat, hst_en, hst_we, hst_a, hst_d, cfg_rack, cfg_q,
      output s_rdy, hst_rdy, hst_rack, hst_q, cfg_en, cfg_we, cfg_a, cfg_d
   );
   modport master (
      output s_vld, s_dat, hst_en, hst_we, hst_a, hst_d, cfg_rack, cfg_q,
      input  s_rdy, hst_rdy, hst_rack, hst_q, cfg_en, cfg_we, cfg_a, cfg_d
   );
endinterface

`default_nettype wire

// File: rtl/thresholding_cfg_ctrl.sv
// ----------------------------------------------------------------------------
// thresholding_cfg_ctrl: bulk threshold load, readback verify, host arbitration.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module thresholding_cfg_ctrl #(
   parameter int N      = 4,
   parameter int K      = 16,
   parameter int C      = 8,
   parameter int PE     = 2,
   parameter int VERIFY = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic busy,
   output logic done,
   output logic err,
   thresholding_cfg_ctrl_if.slave bus
);
   localparam int CF  = C / PE;
   localparam int TN  = 2**N - 1;
   localparam int FW  = $clog2(CF);
   localparam int PW  = $clog2(PE);
   localparam int AW  = FW + PW + N;
   localparam int CW  = K + $clog2(C * 2**N);
   localparam int E   = C * TN;
   localparam int HW  = $clog2(N + 2);
   localparam int RW  = $clog2(E + 1);
   localparam int PCW = (PW > 0) ? PW : 1;
   localparam int FCW = (FW > 0) ? FW : 1;

   if (C % PE != 0) begin : g_cf_check
      $error("thresholding_cfg_ctrl: C must be a multiple of PE");
   end

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_RDBK  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    t_q, t_d;
   logic [PCW-1:0]  p_q, p_d;
   logic [FCW-1:0]  f_q, f_d;
   logic [HW-1:0]   ho_q, ho_d;
   logic [RW-1:0]   rack_cnt_q, rack_cnt_d;
   logic [CW-1:0]   cs_w_q, cs_w_d;
   logic [CW-1:0]   cs_r_q, cs_r_d;
   logic            err_q, err_d;
   logic            cfg_en_q, cfg_en_d;
   logic            cfg_we_q, cfg_we_d;
   logic [AW-1:0]   cfg_a_q, cfg_a_d;
   logic [K-1:0]    cfg_d_q, cfg_d_d;

   logic            start_take;
   logic            hst_take;
   logic            adv;
   logic            last_entry;
   logic [AW-1:0]   addr;

   // {f,p,t} packing built with shifts so a single-PE build still elaborates
   assign addr = (AW'(f_q) << (PW + N)) | (AW'(p_q) << N) | AW'(t_q);
   assign last_entry = (t_q == N'(TN - 1)) && (p_q == PCW'(PE - 1)) && (f_q == FCW'(CF - 1));

   assign start_take = (state_q == S_IDLE) && start && (ho_q == '0);
   assign hst_take   = bus.hst_en && (state_q == S_IDLE) && !start_take;

   assign busy         = (state_q != S_IDLE);
   assign done         = (state_q == S_DONE);
   assign err          = err_q;
   assign bus.s_rdy    = (state_q == S_LOAD);
   assign bus.hst_rdy  = hst_take;
   assign bus.hst_rack = bus.cfg_rack && (state_q == S_IDLE);
   assign bus.hst_q    = bus.cfg_q;
   assign bus.cfg_en   = cfg_en_q;
   assign bus.cfg_we   = cfg_we_q;
   assign bus.cfg_a    = cfg_a_q;
   assign bus.cfg_d    = cfg_d_q;

   always_comb begin
      state_d    = state_q;
      err_d      = err_q;
      cs_w_d     = cs_w_q;
      cs_r_d     = cs_r_q;
      ho_d       = ho_q;
      rack_cnt_d = rack_cnt_q;
      cfg_en_d   = 1'b0;
      cfg_we_d   = 1'b0;
      cfg_a_d    = cfg_a_q;
      cfg_d_d    = cfg_d_q;
      adv        = 1'b0;

      if (state_q == S_IDLE) begin
         if (hst_take && !bus.hst_we && !bus.cfg_rack) begin
            ho_d = ho_q + HW'(1);
         end else if (!(hst_take && !bus.hst_we) && bus.cfg_rack && (ho_q != '0)) begin
            ho_d = ho_q - HW'(1);
         end
      end

      // readback during verify is consumed here rather than passed to the host
      if (((state_q == S_RDBK) || (state_q == S_DRAIN)) && bus.cfg_rack) begin
         rack_cnt_d = rack_cnt_q + RW'(1);
         cs_r_d     = cs_r_q + CW'(bus.cfg_q);
      end

      case (state_q)
         S_IDLE: begin
            if (start_take) begin
               state_d    = S_LOAD;
               err_d      = 1'b0;
               cs_w_d     = '0;
               cs_r_d     = '0;
               rack_cnt_d = '0;
            end else if (hst_take) begin
               cfg_en_d = 1'b1;
               cfg_we_d = bus.hst_we;
               cfg_a_d  = bus.hst_a;
               cfg_d_d  = bus.hst_d;
            end
         end
         S_LOAD: begin
            if (bus.s_vld) begin
               cfg_en_d = 1'b1;
               cfg_we_d = 1'b1;
               cfg_a_d  = addr;
               cfg_d_d  = bus.s_dat;
               cs_w_d   = cs_w_q + CW'(bus.s_dat);
               adv      = 1'b1;
               if (last_entry) begin
                  state_d = (VERIFY != 0) ? S_RDBK : S_DONE;
               end
            end
         end
         S_RDBK: begin
            cfg_en_d = 1'b1;
            cfg_a_d  = addr;
            adv      = 1'b1;
            if (last_entry) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (rack_cnt_q == RW'(E)) begin
               state_d = S_DONE;
               err_d   = (cs_w_q != cs_r_q);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // t is the fastest index, then p, then f; a full pass returns all to zero
   always_comb begin
      t_d = t_q;
      p_d = p_q;
      f_d = f_q;
      if (adv) begin
         if (t_q == N'(TN - 1)) begin
            t_d = '0;
            if (p_q == PCW'(PE - 1)) begin
               p_d = '0;
               f_d = (f_q == FCW'(CF - 1)) ? '0 : f_q + FCW'(1);
            end else begin
               p_d = p_q + PCW'(1);
            end
         end else begin
            t_d = t_q + N'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         t_q        <= '0;
         p_q        <= '0;
         f_q        <= '0;
         ho_q       <= '0;
         rack_cnt_q <= '0;
         cs_w_q     <= '0;
         cs_r_q     <= '0;
         err_q      <= 1'b0;
         cfg_en_q   <= 1'b0;
         cfg_we_q   <= 1'b0;
         cfg_a_q    <= '0;
         cfg_d_q    <= '0;
      end else begin
         state_q    <= state_d;
         t_q        <= t_d;
         p_q        <= p_d;
         f_q        <= f_d;
         ho_q       <= ho_d;
         rack_cnt_q <= rack_cnt_d;
         cs_w_q     <= cs_w_d;
         cs_r_q     <= cs_r_d;
         err_q      <= err_d;
         cfg_en_q   <= cfg_en_d;
         cfg_we_q   <= cfg_we_d;
         cfg_a_q    <= cfg_a_d;
         cfg_d_q    <= cfg_d_d;
      end
   end
endmodule

`default_nettype wire
